// File: rtl/vdc_inv_pkg.sv
// Shared types and constants for the multi-base Van der Corput inverse.
// Optional sequence checking in the top is enabled by VDC_INV_SEQ_CHECK_EN.
package vdc_inv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } vdc_inv_state_e;

  localparam int unsigned Base2 = 2;
  localparam int unsigned Base3 = 3;
  localparam int unsigned Base7 = 7;

  // Wide enough to count up to SCALE (legal SCALE is at most 11).
  localparam int unsigned CntW = 4;

  function automatic longint unsigned vdc_pow(input int unsigned b, input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * longint'(b);
    end
    return p;
  endfunction

endpackage

// File: rtl/vdc_digit_reverse.sv
// One-base digit reverser: each step peels the least significant base-BASE digit off rem
// and shifts it into acc, so SCALE steps reverse the low SCALE digits.
module vdc_digit_reverse
  import vdc_inv_pkg::*;
#(
  parameter int unsigned BASE  = 2,
  parameter int unsigned SCALE = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] k_o,
  output logic             ovf_o
);

  // acc never reaches BASE^SCALE, so it only needs enough bits to hold BASE^SCALE - 1.
  localparam int unsigned AccW = $clog2(vdc_pow(BASE, SCALE));
  localparam logic [WIDTH-1:0] BaseW = WIDTH'(BASE);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] digit;

  always_comb begin
    digit = rem_q % BaseW;
    rem_d = rem_q;
    acc_d = acc_q;
    if (load_i) begin
      rem_d = din_i;
      acc_d = '0;
    end else if (step_i) begin
      rem_d = rem_q / BaseW;
      acc_d = AccW'(WIDTH'(acc_q) * BaseW + digit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      acc_q <= '0;
    end else begin
      rem_q <= rem_d;
      acc_q <= acc_d;
    end
  end

  assign k_o   = WIDTH'(acc_q);
  // Digits left over after SCALE steps mean the sample was outside [0, BASE^SCALE).
  assign ovf_o = (rem_q != '0);

endmodule

// File: rtl/vdcorput_multi_base_inverse.sv
// Recovers k from scaled base-2/3/7 Van der Corput samples and cross-checks the three bases.
// Define VDC_INV_SEQ_CHECK_EN to flag results whose base-2 k does not follow the previous one.
module vdcorput_multi_base_inverse
  import vdc_inv_pkg::*;
#(
  parameter int unsigned SCALE = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] vdc_in_2,
  input  logic [WIDTH-1:0] vdc_in_3,
  input  logic [WIDTH-1:0] vdc_in_7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] k_out_2,
  output logic [WIDTH-1:0] k_out_3,
  output logic [WIDTH-1:0] k_out_7,
  output logic [2:0]       range_err,
  output logic             k_match,
  output logic             seq_err
);

  vdc_inv_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            match_vld_q, match_vld_d;
  logic            load, step, last_step;
  logic            ovf_2, ovf_3, ovf_7;

  assign load      = (state_q == StIdle) && in_valid;
  assign step      = (state_q == StRun);
  assign last_step = step && (cnt_q == CntW'(SCALE - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    match_vld_d = match_vld_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d     = StRun;
          cnt_d       = '0;
          match_vld_d = 1'b0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          state_d     = StDone;
          match_vld_d = 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      match_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      match_vld_q <= match_vld_d;
    end
  end

  vdc_digit_reverse #(
    .BASE  (Base2),
    .SCALE (SCALE),
    .WIDTH (WIDTH)
  ) u_rev_2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .step_i (step),
    .din_i  (vdc_in_2),
    .k_o    (k_out_2),
    .ovf_o  (ovf_2)
  );

  vdc_digit_reverse #(
    .BASE  (Base3),
    .SCALE (SCALE),
    .WIDTH (WIDTH)
  ) u_rev_3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .step_i (step),
    .din_i  (vdc_in_3),
    .k_o    (k_out_3),
    .ovf_o  (ovf_3)
  );

  vdc_digit_reverse #(
    .BASE  (Base7),
    .SCALE (SCALE),
    .WIDTH (WIDTH)
  ) u_rev_7 (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .step_i (step),
    .din_i  (vdc_in_7),
    .k_o    (k_out_7),
    .ovf_o  (ovf_7)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign range_err = {ovf_7, ovf_3, ovf_2};
  // match_vld holds through IDLE so k_match keeps describing the last result.
  assign k_match   = match_vld_q && (k_out_2 == k_out_3) && (k_out_3 == k_out_7) &&
                     (range_err == 3'b000);

`ifdef VDC_INV_SEQ_CHECK_EN
  localparam logic [WIDTH-1:0] SeqMask = WIDTH'((64'd1 << SCALE) - 64'd1);

  logic [WIDTH-1:0] last_q, last_d;
  logic             seen_q, seen_d;
  logic             seq_err_q, seq_err_d;
  logic             hs;

  assign hs = out_valid_q && out_ready;

  always_comb begin
    last_d    = last_q;
    seen_d    = seen_q;
    seq_err_d = 1'b0;
    if (hs && (range_err == 3'b000)) begin
      seen_d    = 1'b1;
      last_d    = k_out_2;
      seq_err_d = seen_q && (k_out_2 != ((last_q + 1'b1) & SeqMask));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= '0;
      seen_q    <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      seen_q    <= seen_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_vdcorput_multi_base_inverse.sv
// Directed bench for vdcorput_multi_base_inverse with SCALE=8; expected k values are hand-derived.
module tb_vdcorput_multi_base_inverse;

  localparam int unsigned Scale = 8;
`ifdef VDC_INV_SEQ_CHECK_EN
  localparam logic SeqEn = 1'b1;
`else
  localparam logic SeqEn = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] vdc_in_2, vdc_in_3, vdc_in_7;
  logic [31:0] k_out_2, k_out_3, k_out_7;
  logic [2:0]  range_err;
  logic        k_match, seq_err;

  int total = 0;
  int bad   = 0;
  logic seq_seen;

  vdcorput_multi_base_inverse #(
    .SCALE (Scale),
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vdc_in_2  (vdc_in_2),
    .vdc_in_3  (vdc_in_3),
    .vdc_in_7  (vdc_in_7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .k_out_2   (k_out_2),
    .k_out_3   (k_out_3),
    .k_out_7   (k_out_7),
    .range_err (range_err),
    .k_match   (k_match),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [31:0] v2, input logic [31:0] v3, input logic [31:0] v7);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    vdc_in_2 = v2;
    vdc_in_3 = v3;
    vdc_in_7 = v7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // out_valid must stay low until exactly Scale edges after acceptance.
  task automatic wait_done();
    for (int i = 1; i < Scale; i++) begin
      @(posedge clk);
      #1;
      if (i == Scale - 1) check("early_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    check("latency", 32'(out_valid), 32'd1);
  endtask

  task automatic expect_result(input logic [31:0] k2, input logic [31:0] k3,
                               input logic [31:0] k7, input logic [31:0] re,
                               input logic [31:0] km);
    check("k_out_2", k_out_2, k2);
    check("k_out_3", k_out_3, k3);
    check("k_out_7", k_out_7, k7);
    check("range_err", 32'(range_err), re);
    check("k_match", 32'(k_match), km);
  endtask

  task automatic consume(input logic seq_exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    seq_seen  = seq_err;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    check("seq_err", 32'(seq_seen), 32'(seq_exp));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vdc_in_2  = '0;
    vdc_in_3  = '0;
    vdc_in_7  = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_k_out_2", k_out_2, 32'd0);
    check("rst_k_out_7", k_out_7, 32'd0);
    check("rst_range_err", 32'(range_err), 32'd0);
    check("rst_k_match", 32'(k_match), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // k = 1, 2, 4: the third result breaks the +1 sequence.
    accept(32'd128, 32'd2187, 32'd823543);
    wait_done();
    expect_result(32'd1, 32'd1, 32'd1, 32'd0, 32'd1);
    consume(1'b0);
    accept(32'd64, 32'd4374, 32'd1647086);
    wait_done();
    expect_result(32'd2, 32'd2, 32'd2, 32'd0, 32'd1);
    consume(1'b0);
    accept(32'd32, 32'd2916, 32'd3294172);
    wait_done();
    expect_result(32'd4, 32'd4, 32'd4, 32'd0, 32'd1);
    consume(SeqEn);

    // k = 6 after 4, then k = 0 after 6: both out of sequence.
    accept(32'd96, 32'd1458, 32'd4941258);
    wait_done();
    expect_result(32'd6, 32'd6, 32'd6, 32'd0, 32'd1);
    consume(SeqEn);
    accept(32'd0, 32'd0, 32'd0);
    wait_done();
    expect_result(32'd0, 32'd0, 32'd0, 32'd0, 32'd1);
    consume(SeqEn);

    // Base-2 overflow: low 8 digits of 256 are all zero, leftover digit flags range_err.
    accept(32'd256, 32'd2187, 32'd823543);
    wait_done();
    expect_result(32'd0, 32'd1, 32'd1, 32'd1, 32'd0);
    consume(1'b0);

    // Backpressure: outputs hold in DONE and a new in_valid is ignored.
    accept(32'd128, 32'd2187, 32'd823543);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      vdc_in_2 = 32'd96;
      vdc_in_3 = 32'd1458;
      vdc_in_7 = 32'd4941258;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_k_out_2", k_out_2, 32'd1);
    end
    in_valid = 1'b0;
    expect_result(32'd1, 32'd1, 32'd1, 32'd0, 32'd1);
    consume(1'b0);
    @(posedge clk);
    #1;
    check("idle_hold_k_out_3", k_out_3, 32'd1);
    check("idle_hold_k_match", 32'(k_match), 32'd1);

    // Reset during RUN discards the in-flight sample.
    accept(32'd96, 32'd1458, 32'd4941258);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_k_out_7", k_out_7, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    accept(32'd96, 32'd1458, 32'd4941258);
    wait_done();
    expect_result(32'd6, 32'd6, 32'd6, 32'd0, 32'd1);
    consume(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
